// File: rtl/fu_alu_if.sv
// Signal bundle between the execute-stage issue logic and the fu_alu integer unit.
// master drives operands and the issue strobe; slave (the ALU) returns result and flags.
interface fu_alu_if #(
   parameter int unsigned WORD_W = 32
);
   logic              en;
   logic [3:0]        aluop;
   logic [WORD_W-1:0] port_a;
   logic [WORD_W-1:0] port_b;
   logic [WORD_W-1:0] out;
   logic              valid;
   logic              zero;
   logic              negative;
   logic              overflow;

   modport master (
      output en, aluop, port_a, port_b,
      input  out, valid, zero, negative, overflow
   );

   modport slave (
      input  en, aluop, port_a, port_b,
      output out, valid, zero, negative, overflow
   );
endinterface

// File: rtl/fu_alu.sv
// Integer ALU functional unit: RV32I-style shift/add/sub/logic/compare, registered, 1-cycle latency.
// Define FU_ALU_FLAGS_EN to build the zero/negative/overflow flag registers; otherwise they read 0.
module fu_alu #(
   parameter int unsigned WORD_W = 32
) (
   input logic         CLK,
   input logic         nRST,
   fu_alu_if.slave     aluif
);

   localparam int unsigned ShW = $clog2(WORD_W);
   localparam int unsigned Msb = WORD_W - 1;

   localparam logic [3:0] OpSll  = 4'd0;
   localparam logic [3:0] OpSrl  = 4'd1;
   localparam logic [3:0] OpSra  = 4'd2;
   localparam logic [3:0] OpAdd  = 4'd3;
   localparam logic [3:0] OpSub  = 4'd4;
   localparam logic [3:0] OpAnd  = 4'd5;
   localparam logic [3:0] OpOr   = 4'd6;
   localparam logic [3:0] OpXor  = 4'd7;
   localparam logic [3:0] OpSlt  = 4'd10;
   localparam logic [3:0] OpSltu = 4'd11;

   logic [WORD_W-1:0] a;
   logic [WORD_W-1:0] b;
   logic [ShW-1:0]    shamt;
   logic              lt_s;
   logic              lt_u;
   logic [WORD_W-1:0] r;

   logic [WORD_W-1:0] out_q;
   logic              valid_q;

   assign a     = aluif.port_a;
   assign b     = aluif.port_b;
   // Only the low shamt bits steer shifts; upper bits of B are deliberately ignored.
   assign shamt = b[ShW-1:0];
   assign lt_s  = $signed(a) < $signed(b);
   assign lt_u  = a < b;

   always_comb begin
      r = '0;
      case (aluif.aluop)
         OpSll:   r = a << shamt;
         OpSrl:   r = a >> shamt;
         OpSra:   r = $unsigned($signed(a) >>> shamt);
         OpAdd:   r = a + b;
         OpSub:   r = a - b;
         OpAnd:   r = a & b;
         OpOr:    r = a | b;
         OpXor:   r = a ^ b;
         OpSlt:   r = {{(WORD_W-1){1'b0}}, lt_s};
         OpSltu:  r = {{(WORD_W-1){1'b0}}, lt_u};
         default: r = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= aluif.en;
         if (aluif.en) begin
            out_q <= r;
         end
      end
   end

   assign aluif.out   = out_q;
   assign aluif.valid = valid_q;

`ifdef FU_ALU_FLAGS_EN
   logic ovf;
   logic zero_q;
   logic negative_q;
   logic overflow_q;

   always_comb begin
      ovf = 1'b0;
      case (aluif.aluop)
         OpAdd:   ovf = (a[Msb] == b[Msb]) && (r[Msb] != a[Msb]);
         OpSub:   ovf = (a[Msb] != b[Msb]) && (r[Msb] != a[Msb]);
         default: ovf = 1'b0;
      endcase
   end

   // Flags share the result register's enable so they always describe the held result.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
         overflow_q <= 1'b0;
      end else if (aluif.en) begin
         zero_q     <= (r == '0);
         negative_q <= r[Msb];
         overflow_q <= ovf;
      end
   end

   assign aluif.zero     = zero_q;
   assign aluif.negative = negative_q;
   assign aluif.overflow = overflow_q;
`else
   assign aluif.zero     = 1'b0;
   assign aluif.negative = 1'b0;
   assign aluif.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fu_alu.sv
// Scoreboard bench for fu_alu: the driver queues hand-computed results, a negedge monitor checks them.
// Flag expectations follow FU_ALU_FLAGS_EN (forced to 0 when the macro is undefined).
module tb_fu_alu;

`ifdef FU_ALU_FLAGS_EN
   localparam bit FlagsOn = 1'b1;
`else
   localparam bit FlagsOn = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [31:0] out;
      logic        z;
      logic        n;
      logic        v;
   } exp_t;

   logic CLK;
   logic nRST;

   fu_alu_if #(.WORD_W(32)) aluif ();

   fu_alu #(.WORD_W(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .aluif(aluif)
   );

   exp_t sb[$];
   exp_t last;
   int   n_cmp = 0;
   int   n_err = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic void check(string name, logic [31:0] got_out, logic got_z, logic got_n,
                                 logic got_v, logic [31:0] exp_out, logic exp_z, logic exp_n,
                                 logic exp_v);
      n_cmp++;
      if (got_out !== exp_out || got_z !== exp_z || got_n !== exp_n || got_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got out=%h z=%b n=%b v=%b, want out=%h z=%b n=%b v=%b", name,
                  got_out, got_z, got_n, got_v, exp_out, exp_z, exp_n, exp_v);
      end
   endfunction

   // Monitor: every valid result must match the head of the scoreboard; idle cycles must hold.
   always @(negedge CLK) begin
      exp_t e;
      if (nRST) begin
         if (aluif.valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_valid: got valid=1 out=%h, want valid=0", aluif.out);
            end else begin
               e = sb.pop_front();
               check(e.name, aluif.out, aluif.zero, aluif.negative, aluif.overflow,
                     e.out, e.z, e.n, e.v);
               last = e;
            end
         end else begin
            check({"hold_after_", last.name}, aluif.out, aluif.zero, aluif.negative,
                  aluif.overflow, last.out, last.z, last.n, last.v);
         end
      end
   end

   task automatic issue(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] out, logic z, logic n, logic v);
      exp_t e;
      e.name = name;
      e.out  = out;
      e.z    = z & FlagsOn;
      e.n    = n & FlagsOn;
      e.v    = v & FlagsOn;
      aluif.en     = 1'b1;
      aluif.aluop  = op;
      aluif.port_a = a;
      aluif.port_b = b;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      aluif.en = 1'b0;
   endtask

   task automatic idle();
      aluif.en     = 1'b0;
      aluif.aluop  = 4'd3;
      aluif.port_a = 32'hDEAD_BEEF;
      aluif.port_b = 32'h1234_5678;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      last = '{name: "reset", out: 32'h0, z: 1'b0, n: 1'b0, v: 1'b0};
      nRST         = 1'b1;
      aluif.en     = 1'b1;
      aluif.aluop  = 4'd4;
      aluif.port_a = 32'hA5A5_A5A5;
      aluif.port_b = 32'h0F0F_0F0F;
      #1 nRST = 1'b0;
      #1;
      check("reset_async", aluif.out, aluif.zero, aluif.negative, aluif.overflow,
            32'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (aluif.valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid: got valid=%b, want 0", aluif.valid);
      end
      repeat (2) @(posedge CLK);
      #1;
      aluif.en = 1'b0;
      nRST     = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // Back-to-back issue, one result per cycle.
      issue("sll_8_1",       4'd0,  32'h0000_0008, 32'h0000_0001, 32'h0000_0010, 0, 0, 0);
      issue("srl_8_1",       4'd1,  32'h0000_0008, 32'h0000_0001, 32'h0000_0004, 0, 0, 0);
      issue("sra_neg",       4'd2,  32'hC000_0000, 32'h0000_0001, 32'hE000_0000, 0, 1, 0);
      issue("sll_shamt_hi",  4'd0,  32'h0000_0008, 32'h0000_0021, 32'h0000_0010, 0, 0, 0);
      issue("sra_shamt0",    4'd2,  32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 0, 1, 0);
      issue("srl_neg_31",    4'd1,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 0, 0, 0);
      issue("add_2_3",       4'd3,  32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 0, 0, 0);
      issue("sub_6_2",       4'd4,  32'h0000_0006, 32'h0000_0002, 32'h0000_0004, 0, 0, 0);
      issue("add_ovf",       4'd3,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 1);
      issue("sub_zero",      4'd4,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0, 0);
      issue("sub_ovf",       4'd4,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 0, 1);
      issue("add_wrap",      4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0);
      issue("and",           4'd5,  32'h0000_FFFF, 32'h0000_F0E0, 32'h0000_F0E0, 0, 0, 0);
      issue("or",            4'd6,  32'h0000_FFFF, 32'h0000_F0E0, 32'h0000_FFFF, 0, 0, 0);
      issue("xor",           4'd7,  32'h0000_FFFF, 32'h0000_F0E0, 32'h0000_0F1F, 0, 0, 0);
      issue("slt_pos",       4'd10, 32'h0000_F0E0, 32'h0000_FFE0, 32'h0000_0001, 0, 0, 0);
      issue("sltu_big",      4'd11, 32'hF000_FFE0, 32'h0000_F0E0, 32'h0000_0000, 1, 0, 0);
      issue("slt_negpos",    4'd10, 32'hF000_FFE0, 32'h0000_F0E0, 32'h0000_0001, 0, 0, 0);
      issue("rsvd_9",        4'd9,  32'hF000_FFE0, 32'h0000_F0E0, 32'h0000_0000, 1, 0, 0);
      issue("rsvd_15",       4'd15, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0);

      // en pattern 1,1,0,1: valid trails en by one cycle and out holds across the gap.
      issue("hs_add",        4'd3,  32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 0, 0, 0);
      issue("hs_xor",        4'd7,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 0, 1, 0);
      idle();
      issue("hs_sll",        4'd0,  32'h0000_0003, 32'h0000_0004, 32'h0000_0030, 0, 0, 0);
      idle();
      idle();

      // Async reset while a result is being presented.
      issue("pre_reset",     4'd6,  32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 0, 0, 0);
      #2 nRST = 1'b0;
      #1;
      check("reset_midstream", aluif.out, aluif.zero, aluif.negative, aluif.overflow,
            32'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (aluif.valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_midstream_valid: got valid=%b, want 0", aluif.valid);
      end
      sb.delete();
      last = '{name: "reset", out: 32'h0, z: 1'b0, n: 1'b0, v: 1'b0};
      @(posedge CLK);
      #1 nRST = 1'b1;
      idle();
      issue("post_reset",    4'd4,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 0);
      repeat (3) idle();

      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d results outstanding, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fu_alu.md
Name: fu_alu

Overview:
- Integer ALU functional unit in the scalar pipeline's execute stage.
- Computes RV32I-style shift, add/sub, logic and set-less-than results from two operands and a 4-bit opcode.
- Result and status flags are registered, giving a 1-cycle latency.
- Signals are carried on the fu_alu_if interface bundle, instance name aluif.

Parameters:
- WORD_W, 32: operand/result width. The shift amount is taken from the $clog2(WORD_W) LSBs of port_b.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- en  input  1  operation valid/issue strobe for this cycle.
- aluop  input  4  operation select.
- port_a  input  WORD_W  operand A (shift source for shifts).
- port_b  input  WORD_W  operand B (shift amount for shifts).
- out  output  WORD_W  registered result.
- valid  output  1  out/flags hold a result issued on the previous cycle.
- zero  output  1  registered: result == 0.
- negative  output  1  registered: result MSB.
- overflow  output  1  registered: signed overflow of ADD/SUB.

Behaviour:
- Reset: nRST low asynchronously forces out=0, valid=0, zero=0, negative=0, overflow=0, regardless of CLK.
- Reset asserted mid-operation discards the in-flight result.
- aluop encoding (combinational result R):
  - 0 SLL: R = A << B[4:0].
  - 1 SRL: R = A >> B[4:0], logical.
  - 2 SRA: R = A >>> B[4:0], sign-filled.
  - 3 ADD: R = A + B, modulo 2^WORD_W.
  - 4 SUB: R = A - B, modulo 2^WORD_W.
  - 5 AND, 6 OR, 7 XOR: bitwise.
  - 10 SLT: R = 1 if signed A < signed B, else 0.
  - 11 SLTU: R = 1 if unsigned A < unsigned B, else 0.
  - 8, 9, 12-15 reserved: R = 0 and overflow = 0. Not an error.
- Only the shamt bits of port_b affect shifts; the upper bits are ignored. Shift by 0 returns A unchanged.
- Overflow:
  - ADD: set when the operand signs match and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from A.
  - 0 for all other ops.
- Timing: at posedge CLK with en=1, out<=R and flags update from R; valid<=1. Latency is 1 cycle.
- At posedge CLK with en=0: valid<=0; out and flags hold their previous values.
- Back-to-back en every cycle is supported: one result per cycle, no stall, no backpressure.
- Operands and aluop need to be stable only at the sampling edge.
- SLT/SLTU results are zero-extended to WORD_W.
- No internal state beyond the output registers.

Optional Feature:
- Macro FU_ALU_FLAGS_EN.
- Defined: zero, negative and overflow are computed and registered as specified.
- Undefined: the flag logic is omitted and zero/negative/overflow are tied to 0. out/valid behaviour is unchanged.

Test Plan:
- Reset: nRST=0 with garbage inputs and en=1 -> out=0, valid=0, flags 0 with no clock edge needed. Release reset, hold en=0 -> valid stays 0.
- Shifts, with en=1 and one edge each -> valid=1 the following cycle:
  - A=8, B=1, op0 -> out=16.
  - op1 -> out=4.
  - A=0xC0000000, B=1, op2 -> 0xE0000000, negative=1.
  - A=8, B=0x21, op0 -> 16 (upper shamt bits ignored).
- Arithmetic:
  - A=2, B=3, op3 -> 5.
  - A=6, B=2, op4 -> 4.
  - A=0x7FFFFFFF, B=1, op3 -> 0x80000000, overflow=1 (flags macro on).
  - A=5, B=5, op4 -> 0, zero=1.
- Logic, with A=0x0000FFFF, B=0x0000F0E0:
  - op5 -> 0x0000F0E0.
  - op6 -> 0x0000FFFF.
  - op7 -> 0x00000F1F.
- Compare:
  - A=0xF0E0, B=0xFFE0, op10 -> 1.
  - A=0xF000FFE0, B=0xF0E0, op11 -> 0.
  - Same operands, op10 -> 1 (signed negative less than positive).
  - op9 -> 0.
- Handshake: en pulses 1,1,0,1 with differing ops -> valid follows en delayed by 1 cycle; out holds through the en=0 cycle. Async reset asserted mid-stream -> out/valid clear immediately.
